seq_divider: RTL
================

Name: seq_divider

Overview:
- Sequential restoring divider: unsigned WIDTH-bit dividend / divisor, one quotient bit per clock.
- It is the inverse of the team's shift-add sequential multiplier and sits beside it in the arithmetic datapath.
- Shift-subtract datapath with an internal FSM controller and a start/busy/done handshake.
- Results stay registered until the next completion.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned numerator; sampled on the accept edge.
- divisor  input  WIDTH  unsigned denominator; sampled on the accept edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results are valid.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag for the last completed operation.

Behaviour:
- Reset: sampled at a clk edge while reset=0. Result:
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - FSM=IDLE, count=0, internal registers cleared.
- Reset mid-operation aborts the operation: no done, outputs cleared.
- States: IDLE and RUN.
- Accept edge: the edge k where state=IDLE and start=1.
  - divisor != 0:
    - Latch divisor; clear the partial remainder P (WIDTH+1 bits).
    - Load the Q shift register with dividend; count=0.
    - busy<=1, state<=RUN.
  - divisor == 0 (short circuit, no RUN):
    - quotient<=all ones, remainder<=dividend, div_by_zero<=1.
    - done<=1, busy stays 0.
    - done is visible in the cycle after edge k.
- RUN, each edge:
  - {P,Q} shifts left by 1 (Q MSB enters P LSB).
  - trial = P_shifted - divisor, computed at WIDTH+1 bits.
  - trial MSB = 0: P<=trial and Q LSB<=1. Otherwise P<=P_shifted and Q LSB<=0.
  - count<=count+1.
- Completion edge (count == WIDTH-1, i.e. edge k+WIDTH):
  - quotient<=final Q, remainder<=final P[WIDTH-1:0], div_by_zero<=0.
  - done<=1, busy<=0, state<=IDLE.
- Latency: done is high in the cycle after edge k+WIDTH (WIDTH cycles after accept). Throughput is one result per WIDTH cycles.
- done is high for exactly one cycle; it deasserts on the next edge unless that edge completes another operation.
- start while busy=1 is ignored: no queuing, and in-flight operands are unaffected.
- Back-to-back: start=1 in the cycle done=1 is accepted (state is IDLE).
- dividend/divisor may change freely after the accept edge.
- quotient/remainder/div_by_zero hold their values between completions, including while busy.
- Invariant when div_by_zero=0: quotient*divisor + remainder == dividend, and remainder < divisor.
- count width is clog2(WIDTH); the counter never wraps within an operation.
- The unsigned compare uses the WIDTH+1-bit trial so that divisor values >= 2^(WIDTH-1) are handled correctly.

Test Plan:
- 100/7, start pulse at edge k:
  - busy=1 from k+1 to k+WIDTH.
  - done=1 exactly one cycle after edge k+16; quotient=14, remainder=2, div_by_zero=0.
- Corner operands, each run to done:
  - 0xFFFF/1 -> quotient 0xFFFF, remainder 0.
  - 0xFFFF/0xFFFF -> quotient 1, remainder 0.
  - 3/10 -> quotient 0, remainder 3.
  - 0x8000/0x8001 -> quotient 0, remainder 0x8000.
- 5/0:
  - done one cycle after the accept edge; quotient=0xFFFF, remainder=5, div_by_zero=1; busy never asserts.
  - Then 9/3 -> quotient 3, remainder 0, div_by_zero=0.
- Start 50/6, then assert start with 77/2 during busy and change the inputs mid-run -> result is quotient 8, remainder 2; only one done pulse.
- Start 1000/3, hold reset=0 at cycle 5 of RUN for one edge -> all outputs 0 and no done. A following 20/4 -> quotient 5, remainder 0.
- Back-to-back: 17/5, then start=1 in the done cycle with 200/9:
  - 17/5 -> quotient 3, remainder 2.
  - 200/9 -> quotient 22, remainder 2, with done WIDTH cycles later.
  - Random unsigned pairs checked against a reference model.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results are registered and held until the next completed operation.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  count;
  logic [WIDTH:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] div_r;

  logic           accept;
  logic           finish;
  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] p_next;
  logic [WIDTH-1:0] q_next;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (divisor != '0) state_next = RUN;
        end
      end
      RUN: begin
        if (count == LAST) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The WIDTH+1-bit trial keeps the borrow visible even for divisors >= 2^(WIDTH-1).
  always_comb begin
    p_shift = (p << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
    trial   = p_shift - {1'b0, div_r};
    p_next  = trial[WIDTH] ? p_shift : trial;
    q_next  = {q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      p           <= '0;
      q           <= '0;
      div_r       <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end else begin
          div_r <= divisor;
          p     <= '0;
          q     <= dividend;
          count <= '0;
          busy  <= 1'b1;
        end
      end else if (state == RUN) begin
        p     <= p_next;
        q     <= q_next;
        count <= finish ? '0 : count + CW'(1);
        if (finish) begin
          quotient    <= q_next;
          remainder   <= p_next[WIDTH-1:0];
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
      end
    end
  end

endmodule
